alu_mdu_iter: RTL and testbench

//  Iterative RV32M multiply/divide unit beside the single-cycle ALU in each lockstep core.

---
 rtl/alu_mdu_iter_pkg.sv | 44 ++++
 rtl/alu_mdu_iter_step.sv | 41 ++++
 rtl/alu_mdu_iter.sv | 172 +++++++++++++++++
 tb/tb_alu_mdu_iter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   mdu_op_e    : funct3 encodings of the M-extension ops
//   mdu_state_e : FSM state encodings
//   helpers     : op class / operand signedness decode
package alu_mdu_iter_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_CALC  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } mdu_state_e;

  function automatic logic op_is_div(mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(mdu_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL takes the low half, which is identical for signed and unsigned,
  // so it is treated as unsigned on both operands.
  function automatic logic op_a_signed(mdu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(mdu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_mdu_iter_step.sv
// mdu_step: one combinational iteration of the MDU datapath.
//   div_i        : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi_i / lo_i  : accumulator halves (mul: product hi/lo with the multiplier
//                  in lo; div: partial remainder / dividend-quotient)
//   m_i          : multiplicand (mul) or divisor (div)
//   hi_o / lo_o  : accumulator after the step
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rsh;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    addend = lo_i[0] ? m_i : '0;
    sum    = {1'b0, hi_i} + {1'b0, addend};
    // Shifted partial remainder needs XLEN+1 bits before the compare.
    rsh    = {hi_i, lo_i[XLEN-1]};
    ge     = (rsh >= {1'b0, m_i});
    // When ge, rsh - m < m < 2^XLEN, so the low XLEN bits are exact.
    diff   = rsh[XLEN-1:0] - m_i;
    if (div_i) begin
      hi_o = ge ? diff : rsh[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: iterative RV32M multiply/divide unit, one op in flight.
//   clk, rst                : clock, synchronous active-high reset
//   flush                   : abort any in-flight op, return to IDLE
//   in_valid/in_ready       : request handshake; in_op (funct3), in_a, in_b, in_tag
//   out_valid/out_ready     : result handshake; out_result, out_tag, out_dbz
//   busy                    : FSM not in IDLE
// IDLE -> PREP -> CALC (XLEN/UNROLL cycles) -> FIXUP -> DONE; special cases
// (divide by zero, signed overflow) jump PREP -> DONE.
module alu_mdu_iter
  import alu_mdu_iter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             busy
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q;
  logic [XLEN-1:0]  a_q, b_q, m_q, hi_q, lo_q, res_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q, dbz_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, is_div;

  assign accept = in_valid & in_ready;
  assign is_div = op_is_div(op_q);

  // ---- PREP decode: magnitudes, result sign, special cases ----
  logic            neg_a, neg_b, is_dbz, is_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, spec_res;

  always_comb begin
    neg_a   = op_a_signed(op_q) & a_q[XLEN-1];
    neg_b   = op_b_signed(op_q) & b_q[XLEN-1];
    abs_a   = neg_a ? (~a_q + 1'b1) : a_q;
    abs_b   = neg_b ? (~b_q + 1'b1) : b_q;
    is_dbz  = is_div & (b_q == '0);
    is_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) & (a_q == XMIN) & (b_q == '1);
    special = is_dbz | is_ovf;
    if (is_dbz) spec_res = op_is_rem(op_q) ? a_q : '1;
    else        spec_res = op_is_rem(op_q) ? '0  : XMIN;
  end

  // ---- CALC: UNROLL chained steps per cycle ----
  logic [UNROLL:0][XLEN-1:0] hi_c, lo_c;
  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    mdu_step #(.XLEN(XLEN)) u_step (
      .div_i (is_div),
      .hi_i  (hi_c[g]),
      .lo_i  (lo_c[g]),
      .m_i   (m_q),
      .hi_o  (hi_c[g+1]),
      .lo_o  (lo_c[g+1])
    );
  end

  // ---- FIXUP: apply sign and select the result half ----
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    case (op_q)
      OP_MUL:                      fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = neg_q ? (~lo_q + 1'b1) : lo_q;
      default:                     fix_res = neg_q ? (~hi_q + 1'b1) : hi_q;
    endcase
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_valid) state_d = S_PREP;
        S_PREP:  state_d = special ? S_DONE : S_CALC;
        // Counter is loaded with N; this edge takes it to 0.
        S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIXUP;
        S_FIXUP: state_d = S_DONE;
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_ready  = (state_q == S_IDLE) & ~flush;
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign out_result = res_q;
  assign out_tag    = tag_q;
  assign out_dbz    = dbz_q;

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_MUL;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      res_q <= '0;
      tag_q <= '0;
      neg_q <= 1'b0;
      dbz_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= mdu_op_e'(in_op);
        a_q   <= in_a;
        b_q   <= in_b;
        tag_q <= in_tag;
      end
      case (state_q)
        S_PREP: begin
          neg_q <= op_is_rem(op_q) ? neg_a : (neg_a ^ neg_b);
          dbz_q <= is_dbz;
          m_q   <= is_div ? abs_b : abs_a;
          hi_q  <= '0;
          lo_q  <= is_div ? abs_a : abs_b;
          cnt_q <= CW'(N);
          if (special) res_q <= spec_res;
        end
        S_CALC: begin
          hi_q  <= hi_c[UNROLL];
          lo_q  <= lo_c[UNROLL];
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIXUP: res_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_iter.sv
// Self-checking bench for alu_mdu_iter: directed vector table, hand-written
// backpressure / flush / reset sequences, and a short random run against a
// behavioural reference model.
module tb_alu_mdu_iter;
  import alu_mdu_iter_pkg::*;

  localparam int XLEN   = 32;
  localparam int UNROLL = 1;
  localparam int TAG_W  = 5;
  localparam int LAT    = XLEN / UNROLL + 3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_dbz, busy;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  always #5 clk = ~clk;

  alu_mdu_iter #(.XLEN(XLEN), .UNROLL(UNROLL), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_dbz(out_dbz), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one op, wait for out_valid (bounded), sample, then drain if out_ready.
  // lat counts edges from the accept edge (=1) to the edge raising out_valid.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] res, output logic dbz,
                       output logic [4:0] tg, output int lat);
    @(negedge clk);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result; dbz = out_dbz; tg = out_tag;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    int ia, ib;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'h0, a};       ub = {32'h0, b};
    ia = a; ib = b;
    r = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t        vt[16];
  logic [31:0] r;
  logic        d;
  logic [4:0]  t;
  int          l;
  logic        seen;

  function automatic vec_t mk(string nm, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              logic [4:0] tag, logic [31:0] res, logic dbz, int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.tag = tag;
    v.res = res; v.dbz = dbz; v.lat = lat;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

    vt[0]  = mk("mul_7_m3",      OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0, LAT);
    vt[1]  = mk("mulh_min_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0, LAT);
    vt[2]  = mk("mulhu_ff_ff",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0, LAT);
    vt[3]  = mk("mulhsu_m1_ff",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 1'b0, LAT);
    vt[4]  = mk("mulh_m1_7",     OP_MULH,   32'hFFFF_FFFF, 32'd7,         5'd5,  32'hFFFF_FFFF, 1'b0, LAT);
    vt[5]  = mk("mul_wrap",      OP_MUL,    32'h0001_0000, 32'h0001_0000, 5'd6,  32'h0000_0000, 1'b0, LAT);
    vt[6]  = mk("div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 1'b0, LAT);
    vt[7]  = mk("rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 1'b0, LAT);
    vt[8]  = mk("divu_fe_3",     OP_DIVU,   32'hFFFF_FFFE, 32'd3,         5'd9,  32'h5555_5554, 1'b0, LAT);
    vt[9]  = mk("remu_100_7",    OP_REMU,   32'd100,       32'd7,         5'd10, 32'd2,         1'b0, LAT);
    vt[10] = mk("div_7_m2",      OP_DIV,    32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 1'b0, LAT);
    vt[11] = mk("rem_7_m2",      OP_REM,    32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         1'b0, LAT);
    vt[12] = mk("div_5_0",       OP_DIV,    32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1, 2);
    vt[13] = mk("remu_5_0",      OP_REMU,   32'd5,         32'd0,         5'd14, 32'd5,         1'b1, 2);
    vt[14] = mk("div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0, 2);
    vt[15] = mk("rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b0, 2);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result,         32'd0);
    chk("rst_out_tag",    {27'd0, out_tag},   32'd0);
    chk("rst_out_dbz",    {31'd0, out_dbz},   32'd0);
    chk("rst_busy",       {31'd0, busy},      32'd0);
    chk("rst_in_ready",   {31'd0, in_ready},  32'd1);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, r, d, t, l);
      chk({vt[i].nm, "_res"}, r, vt[i].res);
      chk({vt[i].nm, "_dbz"}, {31'd0, d}, {31'd0, vt[i].dbz});
      chk({vt[i].nm, "_tag"}, {27'd0, t}, {27'd0, vt[i].tag});
      chk({vt[i].nm, "_lat"}, 32'(l), 32'(vt[i].lat));
    end

    // Backpressure: DONE held with outputs frozen
    out_ready = 1'b0;
    do_op(OP_DIVU, 32'hFFFF_FFFE, 32'd3, 5'd7, r, d, t, l);
    chk("bp_res", r, 32'h5555_5554);
    chk("bp_lat", 32'(l), 32'(LAT));
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
      chk("bp_hold_result", out_result,         32'h5555_5554);
      chk("bp_hold_tag",    {27'd0, out_tag},   32'd7);
      chk("bp_in_ready",    {31'd0, in_ready},  32'd0);
    end
    // Drain with a request already waiting: no accept on the drain edge
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd2; in_b = 32'd2; in_tag = 5'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_no_accept", {31'd0, busy},      32'd0);
    // Back-to-back ops keep their tags
    do_op(OP_MUL, 32'd6, 32'd7, 5'd3, r, d, t, l);
    chk("b2b0_res", r, 32'd42);
    chk("b2b0_tag", {27'd0, t}, 32'd3);
    do_op(OP_REMU, 32'd50, 32'd8, 5'd9, r, d, t, l);
    chk("b2b1_res", r, 32'd2);
    chk("b2b1_tag", {27'd0, t}, 32'd9);

    // Flush at CALC cycle 10
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd21;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy",      {31'd0, busy},      32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("flush_no_result", {31'd0, seen}, 32'd0);
    // flush in IDLE beats in_valid
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = OP_MUL;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_no_accept", {31'd0, busy}, 32'd0);
    do_op(OP_MUL, 32'd3, 32'd4, 5'd2, r, d, t, l);
    chk("post_flush_res", r, 32'd12);
    chk("post_flush_lat", 32'(l), 32'(LAT));

    // Reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd100; in_b = 32'd0; in_tag = 5'h1F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;   // PREP -> DONE (dbz) leaves result/dbz set
    @(negedge clk);
    in_op = OP_MUL;
    out_ready = 1'b1;
    @(posedge clk); #1;   // drained
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd5; in_b = 32'd5; in_tag = 5'h1E;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rstmid_out_result", out_result,         32'd0);
    chk("rstmid_out_tag",    {27'd0, out_tag},   32'd0);
    chk("rstmid_out_dbz",    {31'd0, out_dbz},   32'd0);
    chk("rstmid_busy",       {31'd0, busy},      32'd0);
    @(negedge clk); rst = 1'b0;

    // Random ops vs reference model
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [4:0]  rtag;
      logic        sp;
      rop  = 3'($urandom_range(0, 7));
      rtag = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: ra = 32'h0;  1: ra = 32'h8000_0000;  2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;  1: rb = 32'h8000_0000;  2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      sp = rop[2] && ((rb == 0) ||
           (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
      do_op(rop, ra, rb, rtag, r, d, t, l);
      chk($sformatf("rand%0d_op%0d_res", k, rop), r, ref_res(rop, ra, rb));
      chk($sformatf("rand%0d_dbz", k), {31'd0, d}, {31'd0, rop[2] && rb == 0});
      chk($sformatf("rand%0d_tag", k), {27'd0, t}, {27'd0, rtag});
      chk($sformatf("rand%0d_lat", k), 32'(l), sp ? 32'd2 : 32'(LAT));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
